// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared register map constants for the interrupt controller
package int_ctrl_pkg;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_POL  = 2'd2;
    localparam logic [1:0] ADDR_PEND = 2'd3;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - multi-flop synchroniser for one asynchronous interrupt line
module int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - maskable edge/level interrupt controller with fixed lowest-index priority
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         irq_in,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [NUM_CH-1:0]         cfg_d,
    output logic [NUM_CH-1:0]         cfg_q,
    output logic                      int_req,
    output logic [$clog2(NUM_CH)-1:0] int_id,
    input  logic                      ack
);

    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] hist;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] edge_mode;
    logic [NUM_CH-1:0] polarity;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] mode_chg;
    logic [NUM_CH-1:0] edge_next;
    logic [NUM_CH-1:0] pend_next;
    logic              ack_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        int_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (irq_in[g]),
            .q     (sync_q[g])
        );
    end

    assign act     = sync_q ^ polarity;
    assign rise    = act & ~hist;
    assign req_vec = pending & mask;
    assign int_req = |req_vec;

    always_comb begin
        int_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                int_id = ID_W'(i);
            end
        end
    end

    assign ack_hit  = ack && int_req && edge_mode[int_id];
    assign ack_clr  = ack_hit ? (NUM_CH'(1) << int_id) : '0;
    assign w1c      = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_d : '0;
    assign mode_chg = (cfg_we && cfg_addr == ADDR_EDGE) ? (cfg_d ^ edge_mode) : '0;

    // Clears are applied before sets so a same-cycle edge always survives an ack or W1C.
    assign edge_next = (pending & ~(w1c | ack_clr)) | (rise & edge_mode);
    assign pend_next = ((edge_mode & edge_next) | (~edge_mode & act)) & ~mode_chg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            mask      <= '0;
            edge_mode <= '0;
            polarity  <= '0;
            pending   <= '0;
        end else begin
            pending <= pend_next;
            // A polarity write preloads history with the post-write level so no edge is seen.
            hist    <= (cfg_we && cfg_addr == ADDR_POL) ? (sync_q ^ cfg_d) : act;
            if (cfg_we && cfg_addr == ADDR_MASK) mask      <= cfg_d;
            if (cfg_we && cfg_addr == ADDR_EDGE) edge_mode <= cfg_d;
            if (cfg_we && cfg_addr == ADDR_POL)  polarity  <= cfg_d;
        end
    end

    always_comb begin
        cfg_q = mask;
        case (cfg_addr)
            ADDR_MASK: cfg_q = mask;
            ADDR_EDGE: cfg_q = edge_mode;
            ADDR_POL:  cfg_q = polarity;
            ADDR_PEND: cfg_q = pending;
            default:   cfg_q = mask;
        endcase
    end

endmodule
